// File: rtl/cv32e40p_tmr_voter_monitor_ft.sv
// rtl/cv32e40p_tmr_voter_monitor_ft.sv - TMR majority voter with per-replica breakage monitor
module cv32e40p_tmr_voter_monitor_ft #(
    parameter int unsigned WIDTH              = 32,
    parameter int unsigned COUNT_BIT          = 8,
    parameter int unsigned INC_DEC_BIT        = 2,
    parameter int unsigned INCREMENT          = 1,
    parameter int unsigned DECREMENT          = 1,
    parameter int unsigned BREAKING_THRESHOLD = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_i,
    input  logic                     clear_i,
    input  logic [2:0][WIDTH-1:0]    data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [2:0]               err_detected_o,
    output logic                     uncorrectable_o,
    output logic [2:0]               broken_o,
    output logic [COUNT_BIT-1:0]     cnt0_o,
    output logic [COUNT_BIT-1:0]     cnt1_o,
    output logic [COUNT_BIT-1:0]     cnt2_o
);

    // Counter arithmetic carries one extra bit so increments saturate instead of wrapping
    localparam int unsigned          CW      = COUNT_BIT + 1;
    localparam logic [INC_DEC_BIT-1:0] INC_C = INC_DEC_BIT'(INCREMENT);
    localparam logic [INC_DEC_BIT-1:0] DEC_C = INC_DEC_BIT'(DECREMENT);
    localparam logic [CW-1:0]        INC_W   = CW'(INC_C);
    localparam logic [CW-1:0]        DEC_W   = CW'(DEC_C);
    localparam logic [CW-1:0]        CNT_MAX = {1'b0, {COUNT_BIT{1'b1}}};

    logic [2:0][COUNT_BIT-1:0] cnt_q, cnt_d;
    logic [2:0]                broken_q, broken_d;

    logic [WIDTH-1:0] rep_a, rep_b, rep_c, majority;
    logic [1:0]       n_broken;

    assign rep_a    = data_i[0];
    assign rep_b    = data_i[1];
    assign rep_c    = data_i[2];
    assign majority = (rep_a & rep_b) | (rep_a & rep_c) | (rep_b & rep_c);
    assign n_broken = 2'(broken_q[0]) + 2'(broken_q[1]) + 2'(broken_q[2]);

    // Select the voted value according to how many replicas are still trusted
    always_comb begin
        data_o          = majority;
        uncorrectable_o = 1'b0;
        case (n_broken)
            2'd0: begin
                data_o          = majority;
                uncorrectable_o = valid_i & (rep_a != rep_b) & (rep_a != rep_c) & (rep_b != rep_c);
            end
            2'd1: begin
                if (broken_q[0]) begin
                    data_o          = rep_b;
                    uncorrectable_o = valid_i & (rep_b != rep_c);
                end else if (broken_q[1]) begin
                    data_o          = rep_a;
                    uncorrectable_o = valid_i & (rep_a != rep_c);
                end else begin
                    data_o          = rep_a;
                    uncorrectable_o = valid_i & (rep_a != rep_b);
                end
            end
            default: begin
                // At most one healthy replica left: nothing can be cross-checked
                uncorrectable_o = 1'b1;
                if (!broken_q[0]) begin
                    data_o = rep_a;
                end else if (!broken_q[1]) begin
                    data_o = rep_b;
                end else if (!broken_q[2]) begin
                    data_o = rep_c;
                end else begin
                    data_o = rep_a;
                end
            end
        endcase
    end

    logic [CW-1:0] cnt_ext [3];
    logic [CW-1:0] inc_sum [3];
    logic [CW-1:0] inc_sat [3];
    logic [CW-1:0] dec_sat [3];
    logic [CW-1:0] cnt_nxt [3];
    logic [2:0]    mismatch;

    for (genvar i = 0; i < 3; i++) begin : g_rep
        assign mismatch[i]       = (data_i[i] != data_o);
        assign err_detected_o[i] = valid_i & ~broken_q[i] & mismatch[i];
        assign cnt_ext[i]        = {1'b0, cnt_q[i]};
        assign inc_sum[i]        = cnt_ext[i] + INC_W;
        assign inc_sat[i]        = (inc_sum[i] > CNT_MAX) ? CNT_MAX : inc_sum[i];
        assign dec_sat[i]        = (cnt_ext[i] < DEC_W) ? '0 : (cnt_ext[i] - DEC_W);
        assign cnt_nxt[i]        = mismatch[i] ? inc_sat[i] : dec_sat[i];
    end

    // Next counter / broken state: clear wins, broken replicas and idle cycles hold
    always_comb begin
        cnt_d    = cnt_q;
        broken_d = broken_q;
        for (int i = 0; i < 3; i++) begin
            if (clear_i) begin
                cnt_d[i]    = '0;
                broken_d[i] = 1'b0;
            end else if (valid_i && !broken_q[i]) begin
                cnt_d[i] = cnt_nxt[i][COUNT_BIT-1:0];
                if (32'(cnt_nxt[i]) >= BREAKING_THRESHOLD) begin
                    broken_d[i] = 1'b1;
                end
            end
        end
    end

    // Monitor state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            broken_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            broken_q <= broken_d;
        end
    end

    assign broken_o = broken_q;
    assign cnt0_o   = cnt_q[0];
    assign cnt1_o   = cnt_q[1];
    assign cnt2_o   = cnt_q[2];

endmodule

// File: tb/tb_cv32e40p_tmr_voter_monitor_ft.sv
// tb/tb_cv32e40p_tmr_voter_monitor_ft.sv - directed scoreboard bench for the TMR voter monitor
module tb_cv32e40p_tmr_voter_monitor_ft;

    logic             clk;
    logic             rst_n;
    logic             valid_i;
    logic             clear_i;
    logic [2:0][31:0] data_i;

    logic [31:0] data_o;
    logic [2:0]  err_o;
    logic        unc_o;
    logic [2:0]  broken_o;
    logic [7:0]  cnt0_o, cnt1_o, cnt2_o;

    logic [31:0] s_data_o;
    logic [2:0]  s_err_o;
    logic        s_unc_o;
    logic [2:0]  s_broken_o;
    logic [1:0]  s_cnt0_o, s_cnt1_o, s_cnt2_o;

    cv32e40p_tmr_voter_monitor_ft dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .clear_i        (clear_i),
        .data_i         (data_i),
        .data_o         (data_o),
        .err_detected_o (err_o),
        .uncorrectable_o(unc_o),
        .broken_o       (broken_o),
        .cnt0_o         (cnt0_o),
        .cnt1_o         (cnt1_o),
        .cnt2_o         (cnt2_o)
    );

    cv32e40p_tmr_voter_monitor_ft #(
        .COUNT_BIT         (2),
        .BREAKING_THRESHOLD(7)
    ) dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .clear_i        (clear_i),
        .data_i         (data_i),
        .data_o         (s_data_o),
        .err_detected_o (s_err_o),
        .uncorrectable_o(s_unc_o),
        .broken_o       (s_broken_o),
        .cnt0_o         (s_cnt0_o),
        .cnt1_o         (s_cnt1_o),
        .cnt2_o         (s_cnt2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int SEL_DATA   = 0;
    localparam int SEL_ERR    = 1;
    localparam int SEL_UNC    = 2;
    localparam int SEL_BROKEN = 3;
    localparam int SEL_CNT0   = 4;
    localparam int SEL_CNT1   = 5;
    localparam int SEL_CNT2   = 6;
    localparam int SEL_SCNT0  = 7;
    localparam int SEL_SBRK   = 8;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] val;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_DATA:   return data_o;
            SEL_ERR:    return 32'(err_o);
            SEL_UNC:    return 32'(unc_o);
            SEL_BROKEN: return 32'(broken_o);
            SEL_CNT0:   return 32'(cnt0_o);
            SEL_CNT1:   return 32'(cnt1_o);
            SEL_CNT2:   return 32'(cnt2_o);
            SEL_SCNT0:  return 32'(s_cnt0_o);
            SEL_SBRK:   return 32'(s_broken_o);
            default:    return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_val(input int sel, input string tag, input logic [31:0] val);
        sb_entry_t e;
        e.sel = sel;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t   e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_vec++;
            assert (obs === e.val)
            else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic set_data(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic v);
        data_i[0] = a;
        data_i[1] = b;
        data_i[2] = c;
        valid_i   = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        valid_i = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        clear_i = 1'b0;
        set_data(32'h0, 32'h0, 32'h0, 1'b0);
        #2;
        expect_val(SEL_BROKEN, "reset_broken", 32'h0);
        expect_val(SEL_CNT0, "reset_cnt0", 32'h0);
        expect_val(SEL_CNT1, "reset_cnt1", 32'h0);
        expect_val(SEL_CNT2, "reset_cnt2", 32'h0);
        expect_val(SEL_UNC, "reset_unc", 32'h0);
        drain();
        tick();
        rst_n = 1'b1;

        // single-bit upset on replica 2
        set_data(32'h5, 32'h5, 32'h4, 1'b1);
        #1;
        expect_val(SEL_DATA, "seu_data", 32'h5);
        expect_val(SEL_ERR, "seu_err", 32'h4);
        expect_val(SEL_UNC, "seu_unc", 32'h0);
        drain();
        tick();
        expect_val(SEL_CNT2, "seu_cnt2_up", 32'h1);
        expect_val(SEL_CNT0, "seu_cnt0", 32'h0);
        drain();
        set_data(32'h5, 32'h5, 32'h5, 1'b1);
        #1;
        expect_val(SEL_ERR, "seu_err_clean", 32'h0);
        drain();
        tick();
        expect_val(SEL_CNT2, "seu_cnt2_down", 32'h0);
        drain();

        // interleaved mismatch/match never breaks
        for (int k = 0; k < 3; k++) begin
            set_data(32'h5, 32'h5, 32'h4, 1'b1);
            tick();
            expect_val(SEL_CNT2, "recov_cnt2_peak", 32'h1);
            drain();
            set_data(32'h5, 32'h5, 32'h5, 1'b1);
            tick();
        end
        expect_val(SEL_CNT2, "recov_cnt2", 32'h0);
        expect_val(SEL_BROKEN, "recov_broken", 32'h0);
        drain();

        // all three pairwise different
        set_data(32'h1, 32'h2, 32'h4, 1'b1);
        #1;
        expect_val(SEL_DATA, "pair_data", 32'h0);
        expect_val(SEL_UNC, "pair_unc", 32'h1);
        expect_val(SEL_ERR, "pair_err", 32'h7);
        drain();
        valid_i = 1'b0;
        #1;
        expect_val(SEL_UNC, "pair_unc_novalid", 32'h0);
        expect_val(SEL_ERR, "pair_err_novalid", 32'h0);
        drain();

        // permanent fault on replica 1
        set_data(32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        tick();
        tick();
        expect_val(SEL_CNT1, "perm_cnt1_2", 32'h2);
        expect_val(SEL_BROKEN, "perm_broken_2", 32'h0);
        drain();
        tick();
        expect_val(SEL_CNT1, "perm_cnt1_3", 32'h3);
        expect_val(SEL_BROKEN, "perm_broken_3", 32'h2);
        drain();
        set_data(32'h33, 32'hFFFF_FFFF, 32'h33, 1'b1);
        #1;
        expect_val(SEL_DATA, "perm_data", 32'h33);
        expect_val(SEL_UNC, "perm_unc", 32'h0);
        expect_val(SEL_ERR, "perm_err", 32'h0);
        drain();
        tick();
        expect_val(SEL_CNT1, "perm_cnt1_frozen", 32'h3);
        expect_val(SEL_CNT0, "perm_cnt0", 32'h0);
        drain();
        do_clear();
        expect_val(SEL_BROKEN, "perm_clear_broken", 32'h0);
        expect_val(SEL_CNT1, "perm_clear_cnt1", 32'h0);
        drain();

        // uncorrectable: replica 2 broken, then replica 1
        set_data(32'h0, 32'h0, 32'h7, 1'b1);
        tick();
        tick();
        tick();
        expect_val(SEL_BROKEN, "unc_broken_r2", 32'h4);
        drain();
        set_data(32'h1, 32'h2, 32'h9, 1'b1);
        #1;
        expect_val(SEL_DATA, "unc_data", 32'h1);
        expect_val(SEL_UNC, "unc_one_broken", 32'h1);
        expect_val(SEL_ERR, "unc_err", 32'h2);
        drain();
        tick();
        tick();
        tick();
        expect_val(SEL_BROKEN, "unc_broken_r12", 32'h6);
        expect_val(SEL_CNT1, "unc_cnt1", 32'h3);
        drain();
        set_data(32'h5, 32'h5, 32'h5, 1'b1);
        #1;
        expect_val(SEL_DATA, "unc2_data", 32'h5);
        expect_val(SEL_UNC, "unc2_unc", 32'h1);
        drain();
        valid_i = 1'b0;
        #1;
        expect_val(SEL_UNC, "unc2_unc_novalid", 32'h1);
        expect_val(SEL_ERR, "unc2_err_novalid", 32'h0);
        drain();
        do_clear();

        // saturation and floor on the 2-bit counter instance
        set_data(32'h1, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        expect_val(SEL_SCNT0, "sat_cnt0", 32'h3);
        expect_val(SEL_SBRK, "sat_broken", 32'h0);
        drain();
        set_data(32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        tick();
        expect_val(SEL_SCNT0, "floor_cnt0_2", 32'h1);
        drain();
        tick();
        tick();
        tick();
        expect_val(SEL_SCNT0, "floor_cnt0_5", 32'h0);
        drain();
        do_clear();

        // clear has priority over a simultaneous update
        set_data(32'h9, 32'h0, 32'h0, 1'b1);
        tick();
        tick();
        tick();
        expect_val(SEL_BROKEN, "clr_broken_pre", 32'h1);
        drain();
        set_data(32'h0, 32'h8, 32'h0, 1'b1);
        clear_i = 1'b1;
        tick();
        expect_val(SEL_BROKEN, "clr_broken", 32'h0);
        expect_val(SEL_CNT0, "clr_cnt0", 32'h0);
        expect_val(SEL_CNT1, "clr_cnt1", 32'h0);
        expect_val(SEL_CNT2, "clr_cnt2", 32'h0);
        drain();
        clear_i = 1'b0;
        valid_i = 1'b0;

        // asynchronous reset between edges
        set_data(32'h3, 32'h0, 32'h0, 1'b1);
        tick();
        tick();
        expect_val(SEL_CNT0, "arst_cnt0_pre", 32'h2);
        drain();
        valid_i = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        expect_val(SEL_CNT0, "arst_cnt0", 32'h0);
        expect_val(SEL_BROKEN, "arst_broken", 32'h0);
        expect_val(SEL_SCNT0, "arst_scnt0", 32'h0);
        drain();
        #1;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cv32e40p_tmr_voter_monitor_ft.md
# cv32e40p_tmr_voter_monitor_ft

Triple-modular-redundancy voter with breakage monitor. It sits directly downstream of every triplicated `_ft` sub-block in the IF stage: prefetch buffer, IF FSM, IF pipeline, aligner and compressed decoder. It takes the three replica copies of one output signal and returns the bitwise-majority value. It also keeps a saturating mismatch counter per replica and flags a replica as permanently broken once its counter reaches the configured threshold. Broken replicas are then excluded from voting.

## Interface
Parameters:
- `WIDTH`, 32, width of the voted signal.
- `COUNT_BIT`, 8, width of each per-replica breakage counter.
- `INC_DEC_BIT`, 2, width of the increment and decrement constants.
- `INCREMENT`, 1, amount added on a replica mismatch.
- `DECREMENT`, 1, amount subtracted on a replica match.
- `BREAKING_THRESHOLD`, 3, counter value at or above which a replica is declared broken.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_i` in 1: the current replica values are meaningful; counters update only when this is high.
- `clear_i` in 1: synchronous clear of all counters and broken flags.
- `data_i` in 3×WIDTH: replica values, index 0..2.
- `data_o` out WIDTH: voted value (combinational).
- `err_detected_o` out 3: replica i differs from `data_o` (combinational, gated by `valid_i`).
- `uncorrectable_o` out 1: no trustworthy value exists (combinational).
- `broken_o` out 3: sticky per-replica broken flags (registered).
- `cnt0_o`, `cnt1_o`, `cnt2_o` out COUNT_BIT each: counter values, for debug and coverage (registered).

## Operation
- **Vote mode, zero broken replicas:** `data_o` is the bitwise majority `(a&b)|(a&c)|(b&c)`.
- **Vote mode, exactly one broken replica:** `data_o` is the healthy replica with the lowest index. `uncorrectable_o` = `valid_i` and (the two healthy replicas differ).
- **Vote mode, two or more broken replicas:** `data_o` is the lowest-index healthy replica, or replica 0 if all three are broken. `uncorrectable_o` = 1 unconditionally.
- **Vote mode, zero broken, all three words pairwise different:** `uncorrectable_o` = `valid_i`. `data_o` is still the bitwise majority.
- **`err_detected_o[i]`:** `valid_i` & !`broken_o[i]` & (`data_i[i]` != `data_o`).
- **Counter update, each valid cycle with no clear, per healthy replica i:**
  - On mismatch: `cnt_i` <= min(`cnt_i` + INCREMENT, 2^COUNT_BIT−1). Arithmetic is done in COUNT_BIT+1 bits so the result saturates and never wraps.
  - On match: `cnt_i` <= max(`cnt_i` − DECREMENT, 0), with floor at 0 and no underflow.
- **Frozen counters:** counters of broken replicas hold their value. All counters hold when `valid_i` = 0.
- **Breakage:** when the next value of `cnt_i` is ≥ BREAKING_THRESHOLD, `broken_o[i]` is set in the same clock edge. It stays set until `clear_i` or reset.
- **`clear_i`:** all counters go to 0 and `broken_o` goes to 000 on the next edge. `clear_i` has priority over a simultaneous `valid_i` update.
- **Simultaneous mismatches:** the counters of all mismatching replicas update independently in the same cycle. Two replicas may break on the same edge.

## Timing
- **Reset (`rst_n` low, asynchronous):** counters = 0, `broken_o` = 000. The combinational outputs follow `data_i` and `valid_i` immediately. Reset mid-operation discards all history.
- **Voter path:** purely combinational, zero-cycle latency. No handshake back-pressure.
- **Counter and broken update latency:**
  - A mismatch sampled at edge N is visible on `cntX_o` after edge N.
  - `broken_o` rises after the edge on which the threshold is reached.
  - From that next cycle the vote excludes the replica.
- **Fastest breakage:** with the defaults, 3 consecutive valid mismatches of the same replica give `broken_o` = 1 after the 3rd edge.
- **Recovery:** an interleaved match pattern (mismatch, match, ...) keeps the counter at or below 1, so the replica never breaks.

## Test plan
- **Single-bit upset:** `data_i` = {0x5, 0x5, 0x4} with `valid_i` for 1 cycle → `data_o` = 0x5, `err_detected_o` = 100, and `cnt2_o` = 1 after the edge. Then 1 matching cycle → `cnt2_o` = 0.
- **Permanent fault:** replica 1 is stuck at 0xFFFF_FFFF while the others hold 0x0, for 3 valid cycles → `broken_o` = 010 after the 3rd edge. The next cycle `data_o` = replica 0. Further mismatches leave `cnt1_o` at 3.
- **Uncorrectable:** with replica 2 broken, drive {0x1, 0x2, x} → `uncorrectable_o` = 1 and `data_o` = 0x1. Break a second replica → `uncorrectable_o` stays at 1 regardless of the data.
- **Saturation and floor:** COUNT_BIT = 2, BREAKING_THRESHOLD = 7 (unreachable); 6 mismatches → counter stays at 3. 5 matches → counter stays at 0.
- **Clear vs. update:** assert `clear_i` and a mismatching `valid_i` together while `broken_o` = 001 → after the edge, `broken_o` = 000 and all counters = 0.
- **Async reset mid-run:** drop `rst_n` between edges while `cnt0_o` = 2 → `cnt0_o` = 0 immediately, with no clock edge needed.
